// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode-side
// buffer head handshake, and the redirect/misalignment path.
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [63:0] pc_out;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_out, misalign_err,
    input  imem_rdata, imem_ready, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out, misalign_err,
    output imem_rdata, imem_ready, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential fetch from RESET_PC into a small FIFO
// feeding decode, with redirect flush and a sticky misaligned-target flag.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'd40,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  fetch_bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, FULL} state_e;

  state_e             state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic               misalign_q, misalign_d;

  logic [31:0]        inst_mem_q [DEPTH];
  logic [63:0]        pc_mem_q   [DEPTH];

  logic               req;
  logic               push;
  logic               pop;
  logic               valid;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    valid      = (count_q != '0);
    req        = (state_q == RUN) && !fetch_bus.redirect_valid;
    push       = req && fetch_bus.imem_ready;
    pop        = valid && fetch_bus.inst_ready;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    misalign_d = misalign_q;

    if (fetch_bus.redirect_valid) begin
      // The flush discards whatever a concurrent pop would have removed anyway.
      fetch_pc_d = {fetch_bus.redirect_pc[63:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      state_d    = RUN;
      if (fetch_bus.redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      unique case (state_q)
        BOOT: state_d = RUN;
        RUN:  if (count_d == CNT_W'(DEPTH)) state_d = FULL;
        FULL: if (pop) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: storage is not reset; entries are only visible when count_q says so.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[tail_q] <= fetch_bus.imem_rdata;
      pc_mem_q[tail_q]   <= fetch_pc_q;
    end
  end

  assign fetch_bus.imem_req     = req;
  assign fetch_bus.imem_addr    = fetch_pc_q;
  assign fetch_bus.inst_valid   = valid;
  assign fetch_bus.inst_out     = valid ? inst_mem_q[head_q] : 32'd0;
  assign fetch_bus.pc_out       = valid ? pc_mem_q[head_q]   : 64'd0;
  assign fetch_bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'd40;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction queue, next fetch address, boot flag, sticky flag.
  logic [31:0] mq_inst [$];
  logic [63:0] mq_pc   [$];
  logic [63:0] m_pc;
  bit          m_boot;
  bit          m_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return !m_boot && !bus.redirect_valid && (mq_inst.size() < DEPTH);
  endfunction

  task automatic check_all();
    bit v;
    v = (mq_inst.size() > 0);
    check("imem_req",     64'(bus.imem_req),     64'(exp_req()));
    check("imem_addr",    bus.imem_addr,         m_pc);
    check("inst_valid",   64'(bus.inst_valid),   64'(v));
    check("inst_out",     64'(bus.inst_out),     v ? 64'(mq_inst[0]) : 64'd0);
    check("pc_out",       bus.pc_out,            v ? mq_pc[0] : 64'd0);
    check("misalign_err", 64'(bus.misalign_err), 64'(m_mis));
  endtask

  // Caller drives inputs at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    bit          do_pop, do_push, do_redir;
    logic [31:0] rdata;
    logic [63:0] rpc;
    #1;
    check_all();
    do_redir = bus.redirect_valid;
    rpc      = bus.redirect_pc;
    do_pop   = (mq_inst.size() > 0) && bus.inst_ready;
    do_push  = exp_req() && bus.imem_ready;
    rdata    = bus.imem_rdata;
    @(posedge clk);
    #1;
    if (do_redir) begin
      mq_inst.delete();
      mq_pc.delete();
      m_pc = {rpc[63:2], 2'b00};
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      if (do_pop) begin
        void'(mq_inst.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_inst.push_back(rdata);
        mq_pc.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    m_boot = 1'b0;
  endtask

  task automatic drive(input bit ir, input bit dr, input bit rv, input logic [63:0] rp);
    bus.imem_ready     = ir;
    bus.inst_ready     = dr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.imem_rdata     = $urandom;
  endtask

  // Asserts reset asynchronously mid-cycle, checks cleared outputs, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    mq_inst.delete();
    mq_pc.delete();
    m_pc   = RESET_PC;
    m_boot = 1'b1;
    m_mis  = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Streaming fetch with both sides always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 64'd0);
      cycle();
    end

    // Decode stalled from reset: buffer fills, request stops, one pop resumes it.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'd0);
      cycle();
    end
    check("full_hold_addr", bus.imem_addr, 64'd48);
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'd0);
      cycle();
    end

    // Drain, then memory stalls for three cycles while the buffer empties.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'd0);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'd0);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'd0);
      cycle();
    end

    // Redirect to 80 with a full buffer, with a concurrent pop.
    drive(1'b1, 1'b1, 1'b1, 64'd80);
    cycle();
    check("redir_addr", bus.imem_addr, 64'd80);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 64'd0);
      cycle();
    end

    // Misaligned target, then aligned redirects keep the flag set.
    drive(1'b1, 1'b1, 1'b1, 64'd82);
    cycle();
    check("misalign_set", 64'(bus.misalign_err), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 64'd200);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 64'd0);
    cycle();

    // Unknown instruction bits pass through unmodified.
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    bus.imem_rdata = 32'hxxxx_5a5a;
    cycle();
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 64'd0);
    cycle();

    // Fetch address wraps past the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 64'd0);
      cycle();
    end

    // Reset mid-stream with a full buffer.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'd0);
      cycle();
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 64'd0);
      cycle();
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rp;
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rp[63:8] = '1;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, rp);
      cycle();
      if (i == 1500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
